branch_predictor: RTL and testbench
===================================

Name: branch_predictor

Overview:
- Branch target buffer (BTB) with 2-bit saturating direction counters, directly upstream of the InstructionFetch stage.
- Each cycle it takes the fetch stage's next-PC (next_program_counter_if_to_bp). On a predicted-taken hit it drives target_bp/target_en_bp so fetch redirects to the predicted target.
- The execute stage trains it with resolved branch outcomes.

Parameters:
- ADDR_W, 14, instruction address width; matches the fetch PC and memory address width.
- INDEX_W, 4, BTB index width; the table has 2^INDEX_W entries, direct-mapped.
- COUNT_W, 16, width of the saturating statistics counters.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- next_program_counter_if_to_bp  in  ADDR_W  lookup address from fetch.
- target_bp  out  ADDR_W  predicted target; 0 when not predicting taken.
- target_en_bp  out  1  high when fetch must redirect to target_bp.
- update_en_ex  in  1  one resolved branch this cycle.
- update_pc_ex  in  ADDR_W  address of the resolved branch.
- update_taken_ex  in  1  resolved direction: 1 = taken.
- update_target_ex  in  ADDR_W  resolved target; valid when taken.
- flush_bp  in  1  synchronous invalidate of all entries.
- predict_count  out  COUNT_W  number of cycles with target_en_bp high; saturating.
- update_count  out  COUNT_W  number of accepted updates; saturating.

Behaviour:
- Address split:
  - index = addr[INDEX_W-1:0]
  - tag = addr[ADDR_W-1:INDEX_W], which is 10 bits at the defaults.
- Entry fields: valid (1), tag, target (ADDR_W), ctr (2 bits). Encoding 0 = strong not-taken, 1 = weak NT, 2 = weak T, 3 = strong T.
- Lookup is combinational on registered table state, so latency is 0 cycles:
  - hit = valid && tag match.
  - target_en_bp = hit && ctr[1].
  - target_bp = target when target_en_bp is high, else 0.
- Update is applied at the rising edge when update_en_ex is high.
- Update on a hit (index matches, valid, tag matches):
  - taken: ctr = min(ctr+1, 3) and target := update_target_ex.
  - not taken: ctr = max(ctr-1, 0); target unchanged.
  - valid stays 1.
- Update on a miss:
  - taken: allocate and overwrite any existing entry. valid := 1, tag, target := update_target_ex, ctr := 2.
  - not taken: no change to the table.
- Lookup and update to the same index in the same cycle: the lookup returns pre-update state, and the new state is visible from the next cycle. No bypass.
- flush_bp:
  - At the next edge, all valid := 0 and all ctr := 0.
  - flush_bp has priority over a coincident update; that update is dropped and not counted.
  - Statistics counters are not cleared by flush.
- Reset: asynchronous, active-high.
  - While rst is high: all valid = 0, all ctr = 0, all tags and targets = 0.
  - Also while rst is high: predict_count = 0, update_count = 0, target_en_bp = 0, target_bp = 0.
  - Reset mid-update discards the update.
  - Normal operation resumes at the first edge after rst deasserts.
- predict_count increments at each edge where target_en_bp is high; it holds at 2^COUNT_W-1.
- update_count increments at each edge with update_en_ex high and flush_bp low; it saturates the same way.
- There are no X outputs after reset. Outputs are driven even for untouched entries, whose valid = 0.

Test Plan:
- Reset then lookup: rst pulse, then lookup addresses 0..15 → target_en_bp = 0, target_bp = 0, predict_count = 0.
- Allocate: update pc 5, taken, target 32 → next cycle, lookup 5 gives target_en_bp = 1, target_bp = 32, predict_count increments once per lookup cycle.
- Counter hysteresis: from ctr = 2 at pc 5, one not-taken update → ctr = 1, target_en_bp = 0 on lookup 5. Then two taken updates with target 2 → ctr = 3, target_bp = 2. Then one not-taken update → still predicts taken (ctr = 2).
- Aliasing:
  - Entry at pc 5 (target 32) exists; lookup 21 (same index, different tag) → target_en_bp = 0.
  - Taken update pc 21, target 40 → lookup 21 predicts 40, lookup 5 misses.
- Same-cycle collision and flush:
  - Update pc 7 taken together with lookup 7 → that cycle target_en_bp = 0, next cycle target_en_bp = 1.
  - flush_bp together with an update → all lookups miss, update_count unchanged.
- Async reset mid-run: assert rst between clock edges while an entry predicts taken → target_en_bp drops to 0 immediately without waiting for a clock edge, and both counters read 0.

Source files
------------

// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with 2-bit direction counters.
// Zero-latency lookup for fetch, trained by resolved branches from execute.
module branch_predictor #(
    parameter int ADDR_W  = 14,
    parameter int INDEX_W = 4,
    parameter int COUNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [ADDR_W-1:0]  next_program_counter_if_to_bp,
    output logic [ADDR_W-1:0]  target_bp,
    output logic               target_en_bp,
    input  logic               update_en_ex,
    input  logic [ADDR_W-1:0]  update_pc_ex,
    input  logic               update_taken_ex,
    input  logic [ADDR_W-1:0]  update_target_ex,
    input  logic               flush_bp,
    output logic [COUNT_W-1:0] predict_count,
    output logic [COUNT_W-1:0] update_count
);
    localparam int ENTRIES = 1 << INDEX_W;
    localparam int TAG_W   = ADDR_W - INDEX_W;

    logic [ENTRIES-1:0] valid_q;
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [ADDR_W-1:0]  target_q [ENTRIES];
    logic [1:0]         ctr_q    [ENTRIES];

    logic [COUNT_W-1:0] predict_count_q, predict_count_d;
    logic [COUNT_W-1:0] update_count_q, update_count_d;

    logic [INDEX_W-1:0] lk_idx;
    logic [TAG_W-1:0]   lk_tag;
    logic               lk_hit;

    assign lk_idx = next_program_counter_if_to_bp[INDEX_W-1:0];
    assign lk_tag = next_program_counter_if_to_bp[ADDR_W-1:INDEX_W];
    assign lk_hit = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);

    assign target_en_bp = lk_hit && ctr_q[lk_idx][1];
    assign target_bp    = target_en_bp ? target_q[lk_idx] : '0;

    logic [INDEX_W-1:0] up_idx;
    logic [TAG_W-1:0]   up_tag;
    logic               up_hit;
    logic               wr_en;
    logic [ADDR_W-1:0]  wr_target_d;
    logic [1:0]         wr_ctr_d;

    assign up_idx = update_pc_ex[INDEX_W-1:0];
    assign up_tag = update_pc_ex[ADDR_W-1:INDEX_W];
    assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

    always_comb begin
        wr_en       = 1'b0;
        wr_target_d = target_q[up_idx];
        wr_ctr_d    = ctr_q[up_idx];
        if (update_en_ex) begin
            if (up_hit) begin
                wr_en = 1'b1;
                if (update_taken_ex) begin
                    wr_target_d = update_target_ex;
                    if (ctr_q[up_idx] != 2'd3)
                        wr_ctr_d = ctr_q[up_idx] + 2'd1;
                end else if (ctr_q[up_idx] != 2'd0) begin
                    wr_ctr_d = ctr_q[up_idx] - 2'd1;
                end
            end else if (update_taken_ex) begin
                // Miss with taken outcome replaces whatever aliased here.
                wr_en       = 1'b1;
                wr_target_d = update_target_ex;
                wr_ctr_d    = 2'd2;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= '0;
            end
        end else if (flush_bp) begin
            valid_q <= '0;
            for (int i = 0; i < ENTRIES; i++)
                ctr_q[i] <= '0;
        end else if (wr_en) begin
            valid_q[up_idx]  <= 1'b1;
            tag_q[up_idx]    <= up_tag;
            target_q[up_idx] <= wr_target_d;
            ctr_q[up_idx]    <= wr_ctr_d;
        end
    end

    always_comb begin
        predict_count_d = predict_count_q;
        update_count_d  = update_count_q;
        if (target_en_bp && (predict_count_q != '1))
            predict_count_d = predict_count_q + 1'b1;
        if (update_en_ex && !flush_bp && (update_count_q != '1))
            update_count_d = update_count_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            predict_count_q <= '0;
            update_count_q  <= '0;
        end else begin
            predict_count_q <= predict_count_d;
            update_count_q  <= update_count_d;
        end
    end

    assign predict_count = predict_count_q;
    assign update_count  = update_count_q;
endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor against a table-of-ints
// reference model with randomized traffic.
module tb_branch_predictor;
    localparam int ADDR_W = 14;
    localparam int COUNT_W = 16;
    localparam int NENT = 16;
    localparam int MAXC = 65535;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [ADDR_W-1:0] pc = '0;
    logic [ADDR_W-1:0] tgt;
    logic en;
    logic upd_en = 1'b0;
    logic [ADDR_W-1:0] upd_pc = '0;
    logic upd_tk = 1'b0;
    logic [ADDR_W-1:0] upd_tgt = '0;
    logic flush = 1'b0;
    logic [COUNT_W-1:0] pcnt_o, ucnt_o;

    int errors = 0;
    int checks = 0;

    int mv[NENT], mtag[NENT], mtgt[NENT], mc[NENT];
    int mpcnt, mucnt;

    always #5 clk = ~clk;

    branch_predictor #(.ADDR_W(ADDR_W), .INDEX_W(4), .COUNT_W(COUNT_W)) dut (
        .clk(clk),
        .rst(rst),
        .next_program_counter_if_to_bp(pc),
        .target_bp(tgt),
        .target_en_bp(en),
        .update_en_ex(upd_en),
        .update_pc_ex(upd_pc),
        .update_taken_ex(upd_tk),
        .update_target_ex(upd_tgt),
        .flush_bp(flush),
        .predict_count(pcnt_o),
        .update_count(ucnt_o)
    );

    function automatic int m_en(int a);
        int i = a % NENT;
        return (mv[i] != 0 && mtag[i] == a / NENT && mc[i] >= 2) ? 1 : 0;
    endfunction

    function automatic int m_tgt(int a);
        return m_en(a) != 0 ? mtgt[a % NENT] : 0;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < NENT; i++) begin
            mv[i] = 0; mtag[i] = 0; mtgt[i] = 0; mc[i] = 0;
        end
        mpcnt = 0;
        mucnt = 0;
    endtask

    task automatic drive(int l, int ue, int up, int tk, int t, int f);
        pc = l[ADDR_W-1:0];
        upd_en = ue[0];
        upd_pc = up[ADDR_W-1:0];
        upd_tk = tk[0];
        upd_tgt = t[ADDR_W-1:0];
        flush = f[0];
    endtask

    task automatic tick();
        int pe, i, tg, hit;
        pe = m_en(int'(pc));
        @(posedge clk);
        if (!rst) begin
            if (pe != 0 && mpcnt < MAXC) mpcnt++;
            if (flush) begin
                for (int k = 0; k < NENT; k++) begin
                    mv[k] = 0; mc[k] = 0;
                end
            end else if (upd_en) begin
                if (mucnt < MAXC) mucnt++;
                i = int'(upd_pc) % NENT;
                tg = int'(upd_pc) / NENT;
                hit = (mv[i] != 0 && mtag[i] == tg) ? 1 : 0;
                if (hit != 0) begin
                    if (upd_tk) begin
                        mc[i] = (mc[i] + 1 > 3) ? 3 : mc[i] + 1;
                        mtgt[i] = int'(upd_tgt);
                    end else begin
                        mc[i] = (mc[i] - 1 < 0) ? 0 : mc[i] - 1;
                    end
                end else if (upd_tk) begin
                    mv[i] = 1; mtag[i] = tg; mtgt[i] = int'(upd_tgt); mc[i] = 2;
                end
            end
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        m_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int a = 0; a < 16; a++) begin
            drive(a, 0, 0, 0, 0, 0);
            #1;
            checks++;
            if (en !== 1'b0 || tgt !== '0 || pcnt_o !== '0) begin
                errors++;
                $display("FAIL reset_lookup pc=%0d: got en=%0b tgt=%0d pc=%0d want 0/0/0",
                         a, en, tgt, pcnt_o);
            end
            tick();
        end
    endtask

    task automatic test_allocate();
        drive(0, 1, 5, 1, 32, 0);
        tick();
        for (int n = 0; n < 3; n++) begin
            drive(5, 0, 0, 0, 0, 0);
            #1;
            checks++;
            if (en !== 1'b1 || int'(tgt) != 32 || int'(pcnt_o) != mpcnt) begin
                errors++;
                $display("FAIL allocate n=%0d: got en=%0b tgt=%0d pcnt=%0d want 1/32/%0d",
                         n, en, tgt, pcnt_o, mpcnt);
            end
            tick();
        end
        checks++;
        if (int'(pcnt_o) != mpcnt || int'(ucnt_o) != mucnt) begin
            errors++;
            $display("FAIL allocate_counts: got %0d/%0d want %0d/%0d",
                     pcnt_o, ucnt_o, mpcnt, mucnt);
        end
    endtask

    task automatic test_hysteresis();
        int seq_tk[4] = '{0, 1, 1, 0};
        for (int s = 0; s < 4; s++) begin
            drive(0, 1, 5, seq_tk[s], 2, 0);
            tick();
            drive(5, 0, 0, 0, 0, 0);
            #1;
            checks++;
            if (int'(en) != m_en(5) || int'(tgt) != m_tgt(5)) begin
                errors++;
                $display("FAIL hysteresis step=%0d: got en=%0b tgt=%0d want %0d/%0d",
                         s, en, tgt, m_en(5), m_tgt(5));
            end
            tick();
        end
    endtask

    task automatic test_alias();
        drive(0, 1, 5, 1, 32, 0);
        tick();
        drive(21, 0, 0, 0, 0, 0);
        #1;
        checks++;
        if (en !== 1'b0 || tgt !== '0) begin
            errors++;
            $display("FAIL alias_miss: got en=%0b tgt=%0d want 0/0", en, tgt);
        end
        drive(21, 1, 21, 1, 40, 0);
        tick();
        #1;
        checks++;
        if (en !== 1'b1 || int'(tgt) != 40) begin
            errors++;
            $display("FAIL alias_replace: got en=%0b tgt=%0d want 1/40", en, tgt);
        end
        drive(5, 0, 0, 0, 0, 0);
        #1;
        checks++;
        if (en !== 1'b0 || tgt !== '0) begin
            errors++;
            $display("FAIL alias_evicted: got en=%0b tgt=%0d want 0/0", en, tgt);
        end
        tick();
    endtask

    task automatic test_collision();
        drive(7, 1, 7, 1, 100, 0);
        #1;
        checks++;
        if (en !== 1'b0) begin
            errors++;
            $display("FAIL collision_same_cycle: got en=%0b want 0", en);
        end
        tick();
        drive(7, 0, 0, 0, 0, 0);
        #1;
        checks++;
        if (en !== 1'b1 || int'(tgt) != 100) begin
            errors++;
            $display("FAIL collision_next_cycle: got en=%0b tgt=%0d want 1/100", en, tgt);
        end
        tick();
    endtask

    task automatic test_flush();
        int uc_before;
        uc_before = int'(ucnt_o);
        drive(0, 1, 9, 1, 55, 1);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        for (int a = 0; a < 32; a++) begin
            pc = a[ADDR_W-1:0];
            #1;
            checks++;
            if (en !== 1'b0 || tgt !== '0) begin
                errors++;
                $display("FAIL flush_lookup pc=%0d: got en=%0b tgt=%0d want 0/0", a, en, tgt);
            end
        end
        checks++;
        if (int'(ucnt_o) != uc_before || int'(ucnt_o) != mucnt) begin
            errors++;
            $display("FAIL flush_update_count: got %0d want %0d", ucnt_o, uc_before);
        end
        tick();
    endtask

    task automatic test_random();
        int ue, f;
        for (int n = 0; n < 400; n++) begin
            ue = ($urandom_range(0, 3) != 0) ? 1 : 0;
            f = ($urandom_range(0, 39) == 0) ? 1 : 0;
            drive($urandom_range(0, 63), ue, $urandom_range(0, 63),
                  $urandom_range(0, 1), $urandom_range(0, 16383), f);
            #1;
            checks++;
            if (int'(en) != m_en(int'(pc)) || int'(tgt) != m_tgt(int'(pc))) begin
                errors++;
                $display("FAIL random_lookup n=%0d pc=%0d: got en=%0b tgt=%0d want %0d/%0d",
                         n, pc, en, tgt, m_en(int'(pc)), m_tgt(int'(pc)));
            end
            tick();
        end
        drive(0, 0, 0, 0, 0, 0);
        #1;
        checks++;
        if (int'(pcnt_o) != mpcnt || int'(ucnt_o) != mucnt) begin
            errors++;
            $display("FAIL random_counts: got %0d/%0d want %0d/%0d",
                     pcnt_o, ucnt_o, mpcnt, mucnt);
        end
    endtask

    task automatic test_async_reset();
        drive(0, 1, 5, 1, 77, 0);
        tick();
        drive(5, 0, 0, 0, 0, 0);
        #1;
        checks++;
        if (en !== 1'b1 || int'(tgt) != 77) begin
            errors++;
            $display("FAIL async_pre: got en=%0b tgt=%0d want 1/77", en, tgt);
        end
        drive(5, 1, 5, 1, 88, 0);
        rst = 1'b1;
        #1;
        checks++;
        if (en !== 1'b0 || tgt !== '0 || pcnt_o !== '0 || ucnt_o !== '0) begin
            errors++;
            $display("FAIL async_reset: got en=%0b tgt=%0d pc=%0d uc=%0d want 0",
                     en, tgt, pcnt_o, ucnt_o);
        end
        m_reset();
        @(posedge clk);
        #1 rst = 1'b0;
        drive(5, 0, 0, 0, 0, 0);
        #1;
        checks++;
        if (en !== 1'b0 || pcnt_o !== '0 || ucnt_o !== '0) begin
            errors++;
            $display("FAIL async_discard: got en=%0b pc=%0d uc=%0d want 0/0/0",
                     en, pcnt_o, ucnt_o);
        end
        tick();
    endtask

    initial begin
        m_reset();
        test_reset();
        test_allocate();
        test_hysteresis();
        test_alias();
        test_collision();
        test_flush();
        test_random();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
